// File: rtl/riscv_xc_pkg.sv
// Shared constants and state encoding for the XCrypto xc.init sequencer.
package riscv_xc_pkg;

  localparam int           XC_BANK_BIT  = 6;
  localparam int           NUM_XC_WORDS = 16;
  localparam logic [6:0]   XC_ADDR_BASE = 7'(1 << XC_BANK_BIT);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    DRAIN = 2'd1,
    CLEAR = 2'd2,
    DONE  = 2'd3
  } xc_init_state_e;

endpackage

// File: rtl/riscv_xc_init_sequencer.sv
// xc.init sequencer: zeroes every XC register through write port B while holding ID.
// Core port-B writebacks always win; a colliding cycle simply delays the clear by one.
module riscv_xc_init_sequencer #(
  parameter int ADDR_WIDTH   = 7,
  parameter int DATA_WIDTH   = 32,
  parameter int NUM_XC_WORDS = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start_i,
  input  logic                  flush_i,
  input  logic                  wb_pending_i,
  input  logic                  we_b_i,
  input  logic [ADDR_WIDTH-1:0] waddr_b_i,
  input  logic [DATA_WIDTH-1:0] wdata_b_i,
  output logic                  rf_we_b_o,
  output logic [ADDR_WIDTH-1:0] rf_waddr_b_o,
  output logic [DATA_WIDTH-1:0] rf_wdata_b_o,
  output logic                  halt_id_o,
  output logic                  busy_o,
  output logic                  cprs_init_o,
  output logic                  done_o
);
  import riscv_xc_pkg::*;

  localparam int               IDX_W    = $clog2(NUM_XC_WORDS);
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(NUM_XC_WORDS - 1);

  xc_init_state_e          state_q, state_d;
  logic [IDX_W-1:0]        idx_q, idx_d;
  logic [ADDR_WIDTH-1:0]   clr_addr;

  // Index is zero-extended into the XC bank, so no clear can reach an integer/FP register.
  assign clr_addr = ADDR_WIDTH'(XC_ADDR_BASE) | ADDR_WIDTH'(idx_q);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      idx_q   <= '0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
    end
  end

  always_comb begin
    state_d      = state_q;
    idx_d        = idx_q;
    rf_we_b_o    = we_b_i;
    rf_waddr_b_o = waddr_b_i;
    rf_wdata_b_o = wdata_b_i;

    unique case (state_q)
      IDLE: begin
        if (start_i) state_d = DRAIN;
      end
      DRAIN: begin
        if (flush_i) begin
          state_d = IDLE;
        end else if (!wb_pending_i) begin
          state_d = CLEAR;
          idx_d   = '0;
        end
      end
      CLEAR: begin
        // Once here the instruction is committed, so flush_i is deliberately not examined.
        if (!we_b_i) begin
          rf_we_b_o    = 1'b1;
          rf_waddr_b_o = clr_addr;
          rf_wdata_b_o = '0;
          idx_d        = idx_q + IDX_W'(1);
          if (idx_q == IDX_LAST) state_d = DONE;
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  assign busy_o      = (state_q != IDLE);
  assign halt_id_o   = (state_q != IDLE);
  assign cprs_init_o = (state_q == CLEAR);
  assign done_o      = (state_q == DONE);

endmodule

// File: tb/tb_riscv_xc_init_sequencer.sv
// Self-checking bench for riscv_xc_init_sequencer: directed scenarios plus random traffic
// compared every cycle against a count-based behavioural model.
module tb_riscv_xc_init_sequencer;

  localparam int AW = 7;
  localparam int DW = 32;
  localparam int NW = 16;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          start_i = 1'b0, flush_i = 1'b0, wb_pending_i = 1'b0, we_b_i = 1'b0;
  logic [AW-1:0] waddr_b_i = '0;
  logic [DW-1:0] wdata_b_i = '0;
  logic          rf_we_b_o;
  logic [AW-1:0] rf_waddr_b_o;
  logic [DW-1:0] rf_wdata_b_o;
  logic          halt_id_o, busy_o, cprs_init_o, done_o;

  riscv_xc_init_sequencer #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .NUM_XC_WORDS(NW)) dut (
    .clk(clk), .rst(rst), .start_i(start_i), .flush_i(flush_i),
    .wb_pending_i(wb_pending_i), .we_b_i(we_b_i), .waddr_b_i(waddr_b_i),
    .wdata_b_i(wdata_b_i), .rf_we_b_o(rf_we_b_o), .rf_waddr_b_o(rf_waddr_b_o),
    .rf_wdata_b_o(rf_wdata_b_o), .halt_id_o(halt_id_o), .busy_o(busy_o),
    .cprs_init_o(cprs_init_o), .done_o(done_o)
  );

  always #5 clk = ~clk;

  int n_vec = 0;
  int n_err = 0;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // Model: waiting for drain, number of words cleared so far (-1 when not clearing), done flag.
  bit m_wait;
  int m_cleared;
  bit m_done;

  function automatic void model_reset();
    m_wait = 0; m_cleared = -1; m_done = 0;
  endfunction

  function automatic void model_step();
    if (m_done) begin
      m_done = 0;
    end else if (m_cleared >= 0) begin
      if (!we_b_i) m_cleared++;
      if (m_cleared == NW) begin
        m_cleared = -1;
        m_done    = 1;
      end
    end else if (m_wait) begin
      if (flush_i) m_wait = 0;
      else if (!wb_pending_i) begin
        m_wait    = 0;
        m_cleared = 0;
      end
    end else if (start_i) begin
      m_wait = 1;
    end
  endfunction

  task automatic check_outputs();
    bit            busy;
    bit            clr;
    logic          e_we;
    logic [AW-1:0] e_addr;
    logic [DW-1:0] e_data;
    busy = m_wait || (m_cleared >= 0) || m_done;
    clr  = (m_cleared >= 0) && !we_b_i;
    e_we   = clr ? 1'b1 : we_b_i;
    e_addr = clr ? AW'(7'h40 + m_cleared) : waddr_b_i;
    e_data = clr ? '0 : wdata_b_i;
    chk("rf_we",   64'(rf_we_b_o),    64'(e_we));
    chk("rf_waddr",64'(rf_waddr_b_o), 64'(e_addr));
    chk("rf_wdata",64'(rf_wdata_b_o), 64'(e_data));
    chk("halt_id", 64'(halt_id_o),    64'(busy));
    chk("busy",    64'(busy_o),       64'(busy));
    chk("cprs",    64'(cprs_init_o),  64'(m_cleared >= 0));
    chk("done",    64'(done_o),       64'(m_done));
  endtask

  int cyc = 0;
  int done_cyc = -1;
  int done_cnt = 0;
  int first_clr_cyc = -1;

  task automatic run_cycle(input bit s, input bit f, input bit p, input bit w,
                           input logic [AW-1:0] a, input logic [DW-1:0] d);
    start_i = s; flush_i = f; wb_pending_i = p; we_b_i = w; waddr_b_i = a; wdata_b_i = d;
    @(negedge clk);
    check_outputs();
    if (done_o) begin
      done_cyc = cyc;
      done_cnt++;
    end
    if (first_clr_cyc < 0 && cprs_init_o && rf_we_b_o && !we_b_i) first_clr_cyc = cyc;
    @(posedge clk);
    model_step();
    cyc++;
    #1;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) run_cycle(0, 0, 0, 0, AW'($urandom), $urandom);
  endtask

  task automatic arm();
    done_cyc = -1; done_cnt = 0; first_clr_cyc = -1;
  endtask

  task automatic pulse_reset();
    rst = 1'b1;
    #2;
    model_reset();
    chk("rst_busy", 64'(busy_o), 64'(0));
    chk("rst_halt", 64'(halt_id_o), 64'(0));
    chk("rst_cprs", 64'(cprs_init_o), 64'(0));
    chk("rst_done", 64'(done_o), 64'(0));
    rst = 1'b0;
    #1;
  endtask

  int c0;

  initial begin
    model_reset();
    #2;
    chk("por_busy", 64'(busy_o), 64'(0));
    chk("por_done", 64'(done_o), 64'(0));
    chk("por_pass_we", 64'(rf_we_b_o), 64'(0));
    @(posedge clk); #1;
    rst = 1'b0;
    idle(3);

    // Clean run: done 18 cycles after the start cycle.
    arm(); c0 = cyc;
    run_cycle(1, 0, 0, 0, '0, '0);
    idle(22);
    chk("clean_latency", 64'(done_cyc - c0), 64'(18));
    chk("clean_first_wr", 64'(first_clr_cyc - c0), 64'(2));
    chk("clean_done_cnt", 64'(done_cnt), 64'(1));

    // Drain: pending held for the start cycle plus four more.
    arm(); c0 = cyc;
    run_cycle(1, 0, 1, 0, '0, '0);
    for (int i = 0; i < 4; i++) run_cycle(0, 0, 1, 0, '0, '0);
    idle(24);
    chk("drain_first_wr", 64'(first_clr_cyc - c0), 64'(6));
    chk("drain_latency", 64'(done_cyc - c0), 64'(22));

    // Collision while idx==3.
    arm(); c0 = cyc;
    run_cycle(1, 0, 0, 0, '0, '0);
    idle(4);
    run_cycle(0, 0, 0, 1, 7'h05, 32'hDEADBEEF);
    idle(20);
    chk("coll_latency", 64'(done_cyc - c0), 64'(19));

    // Flush in drain: nothing written, no done.
    arm();
    run_cycle(1, 0, 1, 0, '0, '0);
    run_cycle(0, 1, 1, 0, '0, '0);
    idle(22);
    chk("flush_drain_done", 64'(done_cnt), 64'(0));
    chk("flush_drain_wr", 64'(first_clr_cyc), 64'(-1));

    // Flush during clear is ignored; a re-pulsed start is ignored too.
    arm(); c0 = cyc;
    run_cycle(1, 0, 0, 0, '0, '0);
    idle(3);
    run_cycle(0, 1, 0, 0, '0, '0);
    idle(2);
    run_cycle(1, 0, 0, 0, '0, '0);
    idle(24);
    chk("flush_clr_latency", 64'(done_cyc - c0), 64'(18));
    chk("restart_done_cnt", 64'(done_cnt), 64'(1));

    // Reset after eight clear writes, then a fresh clear from 7'h40.
    arm();
    run_cycle(1, 0, 0, 0, '0, '0);
    idle(9);
    pulse_reset();
    idle(22);
    chk("rst_mid_done_cnt", 64'(done_cnt), 64'(0));
    arm(); c0 = cyc;
    run_cycle(1, 0, 0, 0, '0, '0);
    idle(1);
    chk("rst_restart_addr", 64'(rf_waddr_b_o), 64'(7'h40));
    idle(20);
    chk("rst_restart_latency", 64'(done_cyc - c0), 64'(18));

    // Random traffic against the model.
    for (int i = 0; i < 600; i++) begin
      run_cycle(($urandom % 12) == 0, ($urandom % 16) == 0, $urandom % 2,
                ($urandom % 4) == 0, AW'($urandom), $urandom);
    end
    idle(25);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
